// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults and FSM encoding for the RAM access controller
package ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_FILL    = 3'd4
  } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - command/response port of the RAM access controller
interface ram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/ram_fill_counter.sv
// rtl/ram_fill_counter.sv - fill address counter, saturates at DEPTH-1 and flags terminal count
module ram_fill_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] cnt_o,
  output logic                  tc_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  // Never steps past LAST, so unused address space above DEPTH-1 is not touched.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - command front-end for a single-port RAM with registered-address reads
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_access_ctrl_if.slave      bus,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned DEPTH_U = DEPTH;

  state_e                state_q, state_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_err_q, rd_err_d;

  logic                  cmd_ready, cmd_fire, cmd_in_range;
  logic                  cnt_load, cnt_en, cnt_tc;
  logic [ADDR_WIDTH-1:0] cnt;

  ram_fill_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fill_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  assign cmd_ready    = (state_q == ST_IDLE) && !fill_start && !rst;
  assign cmd_fire     = bus.cmd_valid && cmd_ready;
  assign cmd_in_range = 32'(bus.cmd_addr) < DEPTH_U;

  always_comb begin
    state_d     = state_q;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rd_err_d    = rd_err_q;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d  = ST_FILL;
          cnt_load = 1'b1;
          wren_d   = 1'b1;
          addr_d   = '0;
          data_d   = fill_value;
          busy_d   = 1'b1;
        end else if (cmd_fire) begin
          addr_d = bus.cmd_addr;
          if (bus.cmd_write) begin
            state_d   = ST_WR;
            data_d    = bus.cmd_wdata;
            wren_d    = cmd_in_range;
            rsp_err_d = !cmd_in_range;
          end else begin
            state_d  = ST_RD_ADDR;
            rd_err_d = !cmd_in_range;
          end
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        // ram_q now reflects the address registered by the RAM on the previous edge.
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = rd_err_q;
        rsp_data_d  = rd_err_q ? '0 : ram_q;
      end
      ST_FILL: begin
        if (cnt_tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_en = 1'b1;
          wren_d = 1'b1;
          addr_d = cnt + ADDR_WIDTH'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ram_wren      = wren_q;
  assign ram_address   = addr_q;
  assign ram_data      = data_q;
  assign fill_busy     = busy_q;
  assign fill_done     = done_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed bench driving a 256-deep and a 200-deep instance in lockstep
module tb_ram_access_ctrl;

  typedef enum int {OP_WR, OP_RD, OP_FILL, OP_RST_RD, OP_RST_FILL} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] rd0;
    logic       err0;
    logic [7:0] rd1;
    logic       err1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_write, fill_start;
  logic [7:0] cmd_addr, cmd_wdata, fill_value;
  logic       fill_busy0, fill_done0, wren0, fill_busy1, fill_done1, wren1;
  logic [7:0] addr0, data0, q0, addr1, data1, q1, raddr0, raddr1;
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  ram_access_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
  ram_access_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();

  assign bus0.cmd_valid = cmd_valid;
  assign bus0.cmd_write = cmd_write;
  assign bus0.cmd_addr  = cmd_addr;
  assign bus0.cmd_wdata = cmd_wdata;
  assign bus1.cmd_valid = cmd_valid;
  assign bus1.cmd_write = cmd_write;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus1.cmd_wdata = cmd_wdata;

  ram_access_ctrl #(.DATA_WIDTH(8), .DEPTH(256), .ADDR_WIDTH(8)) u_dut256 (
    .clk(clk), .rst(rst), .bus(bus0), .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy0), .fill_done(fill_done0), .ram_wren(wren0),
    .ram_address(addr0), .ram_data(data0), .ram_q(q0)
  );

  ram_access_ctrl #(.DATA_WIDTH(8), .DEPTH(200), .ADDR_WIDTH(8)) u_dut200 (
    .clk(clk), .rst(rst), .bus(bus1), .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy1), .fill_done(fill_done1), .ram_wren(wren1),
    .ram_address(addr1), .ram_data(data1), .ram_q(q1)
  );

  // 8x256 single-port RAM loads: address registered, q follows one cycle later
  always @(posedge clk) begin
    if (wren0) mem0[addr0] <= data0;
    if (wren1) mem1[addr1] <= data1;
    raddr0 <= addr0;
    raddr1 <= addr1;
  end
  assign q0 = mem0[raddr0];
  assign q1 = mem1[raddr1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(op_e op, logic [7:0] a, logic [7:0] wd,
                              logic [7:0] rd0, logic e0, logic [7:0] rd1, logic e1);
    vec_t v;
    v.op = op; v.addr = a; v.wd = wd; v.rd0 = rd0; v.err0 = e0; v.rd1 = rd1; v.err1 = e1;
    return v;
  endfunction

  task automatic do_write(input vec_t v);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = v.addr; cmd_wdata = v.wd;
    #1;
    check("wr_ready_before", bus0.cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr_wren256", wren0, !v.err0);
    check("wr_addr256", addr0, v.addr);
    check("wr_data256", data0, v.wd);
    check("wr_err256", bus0.rsp_err, v.err0);
    check("wr_wren200", wren1, !v.err1);
    check("wr_err200", bus1.rsp_err, v.err1);
    check("wr_rsp_valid", bus0.rsp_valid | bus1.rsp_valid, 1'b0);
    check("wr_ready_busy", bus0.cmd_ready, 1'b0);
    @(negedge clk);
    check("wr_wren_drop", wren0 | wren1, 1'b0);
    check("wr_err_drop", bus0.rsp_err | bus1.rsp_err, 1'b0);
    check("wr_ready_after", bus0.cmd_ready, 1'b1);
  endtask

  task automatic do_read(input vec_t v);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = v.addr;
    #1;
    check("rd_ready_before", bus0.cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rd_addr_phase_addr", addr0, v.addr);
    check("rd_addr_phase_wren", wren0 | wren1, 1'b0);
    check("rd_addr_phase_rsp", bus0.rsp_valid, 1'b0);
    @(negedge clk);
    check("rd_data_phase_rsp", bus0.rsp_valid | bus1.rsp_valid, 1'b0);
    @(negedge clk);
    check("rd_rsp_valid256", bus0.rsp_valid, 1'b1);
    check("rd_rsp_data256", bus0.rsp_data, v.rd0);
    check("rd_rsp_err256", bus0.rsp_err, v.err0);
    check("rd_rsp_valid200", bus1.rsp_valid, 1'b1);
    check("rd_rsp_data200", bus1.rsp_data, v.rd1);
    check("rd_rsp_err200", bus1.rsp_err, v.err1);
    check("rd_ready_with_rsp", bus0.cmd_ready, 1'b1);
  endtask

  task automatic do_fill(input vec_t v);
    int busy0 = 0, busy1 = 0, done0 = 0, done1 = 0, wr0 = 0, wr1 = 0;
    logic [7:0] last0 = 8'h00, last1 = 8'h00;
    logic rsp_seen = 1'b0;
    fill_start = 1'b1; fill_value = v.wd;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40;
    #1;
    check("fill_blocks_cmd", bus0.cmd_ready | bus1.cmd_ready, 1'b0);
    @(posedge clk);
    for (int c = 0; c < 270; c++) begin
      @(negedge clk);
      if (c == 0) begin fill_start = 1'b0; cmd_valid = 1'b0; end
      if (fill_busy0) busy0++;
      if (fill_busy1) busy1++;
      if (fill_done0) done0++;
      if (fill_done1) done1++;
      if (wren0) begin wr0++; last0 = addr0; end
      if (wren1) begin wr1++; last1 = addr1; end
      if (bus0.rsp_valid | bus1.rsp_valid) rsp_seen = 1'b1;
    end
    check("fill_busy_cycles256", busy0, 256);
    check("fill_busy_cycles200", busy1, 200);
    check("fill_done_pulses256", done0, 1);
    check("fill_done_pulses200", done1, 1);
    check("fill_writes256", wr0, 256);
    check("fill_writes200", wr1, 200);
    check("fill_last_addr256", last0, 8'hFF);
    check("fill_last_addr200", last1, 8'hC7);
    check("fill_no_read_rsp", rsp_seen, 1'b0);
  endtask

  task automatic do_rst_rd(input vec_t v);
    logic seen = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = v.addr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstrd_in_rd_addr", addr0, v.addr);
    rst = 1'b1;
    #1;
    check("rstrd_addr_cleared", addr0, 8'h00);
    check("rstrd_rsp_data_cleared", bus0.rsp_data, 8'h00);
    check("rstrd_ready_low", bus0.cmd_ready, 1'b0);
    repeat (2) begin
      @(negedge clk);
      if (bus0.rsp_valid | bus1.rsp_valid) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.rsp_valid | bus1.rsp_valid) seen = 1'b1;
    end
    check("rstrd_no_rsp", seen, 1'b0);
  endtask

  task automatic do_rst_fill(input vec_t v);
    logic seen = 1'b0;
    fill_start = 1'b1; fill_value = v.wd;
    @(posedge clk);
    @(negedge clk);
    fill_start = 1'b0;
    repeat (99) @(negedge clk);
    check("abort_busy_before", fill_busy0 & fill_busy1, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy256", fill_busy0, 1'b0);
    check("abort_busy200", fill_busy1, 1'b0);
    check("abort_wren", wren0 | wren1, 1'b0);
    check("abort_data", data0, 8'h00);
    check("abort_ready_low", bus0.cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (fill_done0 | fill_done1 | fill_busy0 | fill_busy1) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
  endtask

  task automatic do_b2b();
    logic [7:0] mdl [256];
    logic [7:0] exp_q [$];
    int last_acc = -1;
    logic last_wr = 1'b0;
    int k = 0;
    int nrsp = 0;
    bit load = 1'b1;
    logic [7:0] e;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (load) begin
        load = 1'b0;
        if (k < 16) begin
          cmd_valid = 1'b1;
          cmd_write = (k % 2 == 0);
          cmd_addr  = 8'h20 + 8'(k / 2);
          cmd_wdata = 8'h5B ^ 8'(k * 17);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      #1;
      if (bus0.rsp_valid) begin
        nrsp++;
        check("b2b_rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("b2b_rsp_data256", bus0.rsp_data, e);
          check("b2b_rsp_data200", bus1.rsp_data, e);
          check("b2b_rsp_valid200", bus1.rsp_valid, 1'b1);
          check("b2b_rsp_err", bus0.rsp_err | bus1.rsp_err, 1'b0);
        end
      end
      if (cmd_valid && bus0.cmd_ready) begin
        if (last_acc >= 0) check("b2b_accept_gap", cyc - last_acc, last_wr ? 2 : 3);
        if (cmd_write) mdl[cmd_addr] = cmd_wdata;
        else exp_q.push_back(mdl[cmd_addr]);
        last_acc = cyc;
        last_wr  = cmd_write;
        k++;
        load = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_rsp_count", nrsp, 8);
  endtask

  initial begin
    vec_t vecs[24];
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    fill_start = 1'b0; fill_value = 8'h00;

    vecs[0]  = mk(OP_WR,       8'h10, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[1]  = mk(OP_RD,       8'h10, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0);
    vecs[2]  = mk(OP_WR,       8'hC8, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b1);
    vecs[3]  = mk(OP_RD,       8'hC8, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b1);
    vecs[4]  = mk(OP_WR,       8'hC7, 8'h77, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[5]  = mk(OP_RD,       8'hC7, 8'h00, 8'h77, 1'b0, 8'h77, 1'b0);
    vecs[6]  = mk(OP_WR,       8'hFF, 8'h11, 8'h00, 1'b0, 8'h00, 1'b1);
    vecs[7]  = mk(OP_RD,       8'hFF, 8'h00, 8'h11, 1'b0, 8'h00, 1'b1);
    vecs[8]  = mk(OP_WR,       8'h00, 8'h22, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[9]  = mk(OP_RD,       8'h00, 8'h00, 8'h22, 1'b0, 8'h22, 1'b0);
    vecs[10] = mk(OP_FILL,     8'h00, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[11] = mk(OP_RD,       8'h00, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[12] = mk(OP_RD,       8'h7F, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[13] = mk(OP_RD,       8'hFF, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b1);
    vecs[14] = mk(OP_RD,       8'hC7, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[15] = mk(OP_RD,       8'hC8, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b1);
    vecs[16] = mk(OP_RST_RD,   8'h10, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[17] = mk(OP_WR,       8'h33, 8'h44, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[18] = mk(OP_RD,       8'h33, 8'h00, 8'h44, 1'b0, 8'h44, 1'b0);
    vecs[19] = mk(OP_RST_FILL, 8'h00, 8'hE1, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[20] = mk(OP_RD,       8'h10, 8'h00, 8'hE1, 1'b0, 8'hE1, 1'b0);
    vecs[21] = mk(OP_RD,       8'h7F, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[22] = mk(OP_WR,       8'h05, 8'h99, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[23] = mk(OP_RD,       8'h05, 8'h00, 8'h99, 1'b0, 8'h99, 1'b0);

    repeat (2) @(negedge clk);
    check("rst_ready256", bus0.cmd_ready, 1'b0);
    check("rst_ready200", bus1.cmd_ready, 1'b0);
    check("rst_wren", wren0 | wren1, 1'b0);
    check("rst_addr", addr0, 8'h00);
    check("rst_data", data0, 8'h00);
    check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check("rst_rsp_data", bus0.rsp_data, 8'h00);
    check("rst_rsp_err", bus0.rsp_err, 1'b0);
    check("rst_fill_busy", fill_busy0 | fill_busy1, 1'b0);
    check("rst_fill_done", fill_done0 | fill_done1, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      case (vecs[i].op)
        OP_WR:       do_write(vecs[i]);
        OP_RD:       do_read(vecs[i]);
        OP_FILL:     do_fill(vecs[i]);
        OP_RST_RD:   do_rst_rd(vecs[i]);
        OP_RST_FILL: do_rst_fill(vecs[i]);
        default:     ;
      endcase
    end

    do_b2b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
